hilo_muldiv_seq: RTL

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the HI/LO registers. Sits in EX beside the ALU.

---
 rtl/hilo_muldiv_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: HI/LO owner and multi-cycle MULT/MULTU/DIV/DIVU sequencer.
// Multiply is computed on acceptance and held for MUL_CYCLES busy cycles.
// Divide is radix-2 restoring, one bit per cycle, followed by a sign-fix cycle.
module hilo_muldiv_seq #(
   parameter int         MUL_CYCLES = 4,
   parameter logic [1:0] OP_MULT    = 2'b00,
   parameter logic [1:0] OP_MULTU   = 2'b01,
   parameter logic [1:0] OP_DIV     = 2'b10,
   parameter logic [1:0] OP_DIVU    = 2'b11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        hilo_rd,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_SIGN = 2'd3;

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic [63:0] prod;
   logic [32:0] rem;     // extra bit absorbs the subtract borrow
   logic [31:0] quo;     // dividend shifts out of the top, quotient bits in at the bottom
   logic [31:0] dvs;
   logic [31:0] a_orig;  // original dividend, returned as HI on divide-by-zero
   logic        neg_q;
   logic        neg_r;
   logic        dvz;

   logic        op_mul;
   logic        op_sgn;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod_n;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [33:0] r_sh;
   logic [33:0] diff;
   logic [31:0] q_fin;
   logic [31:0] r_fin;
   logic        last;

   assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign op_sgn = (op == OP_MULT) || (op == OP_DIV);

   assign busy  = (state != S_IDLE);
   assign stall = busy & (start | hilo_rd | hi_we | lo_we) & ~flush;
   assign last  = ((state == S_MUL) && (cnt == 5'd0)) || (state == S_SIGN);
   assign done  = last & ~flush;

   // Operand preparation: sign/zero extension for multiply, magnitudes for signed divide
   always_comb begin
      a_ext  = op_sgn ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
      b_ext  = op_sgn ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
      prod_n = a_ext * b_ext;
      abs_a  = (op_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
      abs_b  = (op_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;
   end

   // One restoring-divide step and the final sign correction
   always_comb begin
      r_sh  = {rem, quo[31]};
      diff  = r_sh - {2'b00, dvs};
      q_fin = neg_q ? (32'd0 - quo) : quo;
      r_fin = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
      if (dvz) begin
         q_fin = 32'hFFFF_FFFF;
         r_fin = a_orig;
      end
   end

   // Sequencer state and working registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= 5'd0;
         prod   <= 64'd0;
         rem    <= 33'd0;
         quo    <= 32'd0;
         dvs    <= 32'd0;
         a_orig <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dvz    <= 1'b0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (op_mul) begin
                     state <= S_MUL;
                     cnt   <= 5'(MUL_CYCLES - 1);
                     prod  <= prod_n;
                  end else begin
                     state  <= S_DIV;
                     cnt    <= 5'd31;
                     rem    <= 33'd0;
                     quo    <= abs_a;
                     dvs    <= abs_b;
                     a_orig <= src_a;
                     neg_q  <= op_sgn & (src_a[31] ^ src_b[31]);
                     neg_r  <= op_sgn & src_a[31];
                     dvz    <= (src_b == 32'd0);
                  end
               end
            end
            S_MUL: begin
               if (cnt == 5'd0) state <= S_IDLE;
               else             cnt   <= cnt - 5'd1;
            end
            S_DIV: begin
               if (diff[33]) begin
                  rem <= r_sh[32:0];
                  quo <= {quo[30:0], 1'b0};
               end else begin
                  rem <= diff[32:0];
                  quo <= {quo[30:0], 1'b1};
               end
               if (cnt == 5'd0) state <= S_SIGN;
               else             cnt   <= cnt - 5'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // HI/LO: results on done; MTHI/MTLO only when idle and not displaced by a start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (done) begin
         if (state == S_MUL) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
         end else begin
            hi <= r_fin;
            lo <= q_fin;
         end
      end else if (!busy && !start && !flush) begin
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;
      end
   end

endmodule
